// File: rtl/mario_pkg.sv
// Shared definitions for Mario's horizontal movement: state encoding,
// screen limits and the per-speed step period table.
package mario_pkg;

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      ACCEL = 2'd1,
      RUN   = 2'd2,
      BRAKE = 2'd3
   } x_state_e;

   localparam int SCREEN_LEFT  = 0;
   localparam int SCREEN_RIGHT = 639;

   localparam logic [2:0] MAX_SPEED = 3'd4;

   // Clocks per pixel at each speed; index 0 means standing still.
   localparam logic [31:0] PERIOD_SPD1 = 32'd40;
   localparam logic [31:0] PERIOD_SPD2 = 32'd30;
   localparam logic [31:0] PERIOD_SPD3 = 32'd20;
   localparam logic [31:0] PERIOD_SPD4 = 32'd12;

   function automatic logic [31:0] step_period(input logic [2:0] speed);
      case (speed)
         3'd1:    return PERIOD_SPD1;
         3'd2:    return PERIOD_SPD2;
         3'd3:    return PERIOD_SPD3;
         3'd4:    return PERIOD_SPD4;
         default: return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/size_variable_step_gen.sv
// Variable-period counter-enable: one-clk step_raw pulse every 'size' clocks,
// silent when size is zero.
module size_variable_step_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] size,
   output logic        step_raw
);

   logic [31:0] count;

   // A size that shrinks below the running count fires immediately and wraps.
   always_comb begin
      step_raw = (size != 32'd0) && (count >= (size - 32'd1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 32'd0;
      end else if ((size == 32'd0) || step_raw) begin
         count <= 32'd0;
      end else begin
         count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/mario_x_move.sv
// Horizontal movement controller: STOP/ACCEL/RUN/BRAKE speed machine driven by
// frame_tick, stepping the sprite one pixel per speed-dependent period.
module mario_x_move
   import mario_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int LEFT_END   = SCREEN_LEFT,
   parameter int RIGHT_END  = SCREEN_RIGHT,
   parameter int START_LEFT = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       left_btn,
   input  logic       right_btn,
   output logic [9:0] left,
   output logic [9:0] right,
   output logic       facing_left,
   output logic       moving,
   output logic [2:0] speed_index,
   output x_state_e   state_dbg
);

   localparam logic [9:0] LEFT_END_C   = 10'(LEFT_END);
   localparam logic [9:0] RIGHT_END_C  = 10'(RIGHT_END);
   localparam logic [9:0] START_LEFT_C = 10'(START_LEFT);
   localparam logic [9:0] WIDTH_M1_C   = 10'(WIDTH - 1);

   x_state_e   state, state_next;
   logic [2:0] idx, idx_next;
   logic       facing, facing_next;
   logic [9:0] left_q;
   logic       sole_l, sole_r, held, blocked;
   logic       step_raw, step;

   // Both buttons together count as no press.
   assign sole_l  = left_btn & ~right_btn;
   assign sole_r  = right_btn & ~left_btn;
   assign held    = facing ? sole_l : sole_r;
   assign right   = left_q + WIDTH_M1_C;
   assign blocked = facing ? (left_q == LEFT_END_C) : (right == RIGHT_END_C);
   assign step    = step_raw & moving;

   size_variable_step_gen u_step_gen (
      .clk      (clk),
      .rst      (rst),
      .size     (step_period(idx)),
      .step_raw (step_raw)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= STOP;
         idx    <= 3'd0;
         facing <= 1'b0;
         left_q <= START_LEFT_C;
      end else begin
         state  <= state_next;
         idx    <= idx_next;
         facing <= facing_next;
         if (step) begin
            if (facing) begin
               if (left_q > LEFT_END_C) left_q <= left_q - 10'd1;
            end else begin
               if (right < RIGHT_END_C) left_q <= left_q + 10'd1;
            end
         end
      end
   end

   always_comb begin
      state_next  = state;
      idx_next    = idx;
      facing_next = facing;
      case (state)
         STOP: begin
            if (frame_tick && (sole_l || sole_r)) begin
               state_next  = ACCEL;
               idx_next    = 3'd1;
               facing_next = sole_l;
            end
         end
         ACCEL: begin
            if (!held) begin
               state_next = BRAKE;
            end else if (frame_tick) begin
               // Saturate: re-entry from BRAKE may already be at top speed.
               idx_next = (idx >= MAX_SPEED - 3'd1) ? MAX_SPEED : idx + 3'd1;
               if (idx_next == MAX_SPEED) state_next = RUN;
            end
         end
         RUN: begin
            if (!held) state_next = BRAKE;
         end
         BRAKE: begin
            if (frame_tick) begin
               if (held) begin
                  state_next = ACCEL;
               end else begin
                  idx_next = idx - 3'd1;
                  if (idx_next == 3'd0) state_next = STOP;
               end
            end
         end
         default: state_next = STOP;
      endcase
      // A step pushing into a wall halts immediately, overriding any frame change.
      if (step && blocked) begin
         state_next = STOP;
         idx_next   = 3'd0;
      end
   end

   always_comb begin
      left        = left_q;
      facing_left = facing;
      speed_index = idx;
      moving      = (state != STOP);
      state_dbg   = state;
   end

endmodule

// File: tb/tb_mario_x_move.sv
// Directed bench for mario_x_move: frame-by-frame state vectors, then step
// timing, async reset and wall-bump sequences.
module tb_mario_x_move;
   import mario_pkg::*;

   logic       clk, rst, frame_tick, left_btn, right_btn;
   logic [9:0] left, right;
   logic       facing_left, moving;
   logic [2:0] speed_index;
   x_state_e   state_dbg;

   int tests_run = 0;
   int tests_failed = 0;

   mario_x_move dut (
      .clk         (clk),
      .rst         (rst),
      .frame_tick  (frame_tick),
      .left_btn    (left_btn),
      .right_btn   (right_btn),
      .left        (left),
      .right       (right),
      .facing_left (facing_left),
      .moving      (moving),
      .speed_index (speed_index),
      .state_dbg   (state_dbg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic       lb;
      logic       rb;
      logic       tick;
      x_state_e   st;
      logic [2:0] idx;
      logic       fl;
   } vec_t;

   localparam int NVEC = 29;
   vec_t vecs [NVEC];

   task automatic check(input string name, input int actual, input int expected);
      tests_run++;
      if (actual != expected) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      left_btn   = 1'b0;
      right_btn  = 1'b0;
      frame_tick = 1'b0;
      rst        = 1'b1;
      #10;
      rst        = 1'b0;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
   endtask

   task automatic wait_left_change(input int max_cyc, output int n, output bit ok);
      logic [9:0] start;
      start = left;
      n = 0;
      while ((left == start) && (n < max_cyc)) begin
         cycle();
         n++;
      end
      ok = (left != start);
   endtask

   task automatic wall_run(input bit go_left, input int max_cyc, input int exp_left);
      int n, n_edge, n_stop;
      bit seen_edge;
      logic [9:0] held_left;
      do_reset();
      left_btn  = go_left;
      right_btn = ~go_left;
      repeat (4) tick();
      check("wall_run_state", int'(state_dbg), int'(RUN));
      n = 0; n_edge = 0; n_stop = -1; seen_edge = 1'b0;
      while (n < max_cyc && n_stop < 0) begin
         cycle();
         n++;
         if (!seen_edge && left == 10'(exp_left)) begin
            seen_edge = 1'b1;
            n_edge = n;
         end
         if (state_dbg == STOP) n_stop = n;
      end
      check("wall_stop_reached", int'(n_stop >= 0), 1);
      check("wall_left", int'(left), exp_left);
      check("wall_right", int'(right), exp_left + 31);
      check("wall_speed", int'(speed_index), 0);
      check("wall_moving", int'(moving), 0);
      check("wall_facing", int'(facing_left), int'(go_left));
      check("wall_bump_delay", n_stop - n_edge, 12);
      held_left = left;
      repeat (30) cycle();
      check("wall_left_hold", int'(left), int'(held_left));
      left_btn  = 1'b0;
      right_btn = 1'b0;
   endtask

   initial begin
      int n;
      bit ok;
      logic [9:0] l0;

      //           lb    rb    tick  state  idx   facing
      vecs[0]  = '{1'b0, 1'b0, 1'b1, STOP,  3'd0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, STOP,  3'd0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, STOP,  3'd0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, ACCEL, 3'd1, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, ACCEL, 3'd2, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, ACCEL, 3'd3, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, RUN,   3'd4, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, RUN,   3'd4, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, BRAKE, 3'd4, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, BRAKE, 3'd3, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b1, BRAKE, 3'd2, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, BRAKE, 3'd2, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 1'b1, ACCEL, 3'd2, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 1'b1, ACCEL, 3'd3, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 1'b0, BRAKE, 3'd3, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 1'b1, BRAKE, 3'd2, 1'b0};
      vecs[16] = '{1'b1, 1'b0, 1'b1, BRAKE, 3'd1, 1'b0};
      vecs[17] = '{1'b1, 1'b0, 1'b1, STOP,  3'd0, 1'b0};
      vecs[18] = '{1'b1, 1'b0, 1'b1, ACCEL, 3'd1, 1'b1};
      vecs[19] = '{1'b1, 1'b1, 1'b0, BRAKE, 3'd1, 1'b1};
      vecs[20] = '{1'b1, 1'b0, 1'b1, ACCEL, 3'd1, 1'b1};
      vecs[21] = '{1'b1, 1'b0, 1'b1, ACCEL, 3'd2, 1'b1};
      vecs[22] = '{1'b1, 1'b0, 1'b1, ACCEL, 3'd3, 1'b1};
      vecs[23] = '{1'b1, 1'b0, 1'b1, RUN,   3'd4, 1'b1};
      vecs[24] = '{1'b1, 1'b1, 1'b0, BRAKE, 3'd4, 1'b1};
      vecs[25] = '{1'b0, 1'b0, 1'b1, BRAKE, 3'd3, 1'b1};
      vecs[26] = '{1'b0, 1'b0, 1'b1, BRAKE, 3'd2, 1'b1};
      vecs[27] = '{1'b0, 1'b0, 1'b1, BRAKE, 3'd1, 1'b1};
      vecs[28] = '{1'b0, 1'b0, 1'b1, STOP,  3'd0, 1'b1};

      do_reset();
      check("reset_left", int'(left), 100);
      check("reset_right", int'(right), 131);
      check("reset_speed", int'(speed_index), 0);
      check("reset_moving", int'(moving), 0);
      check("reset_facing", int'(facing_left), 0);
      check("reset_state", int'(state_dbg), int'(STOP));

      for (int i = 0; i < NVEC; i++) begin
         left_btn   = vecs[i].lb;
         right_btn  = vecs[i].rb;
         frame_tick = vecs[i].tick;
         cycle();
         frame_tick = 1'b0;
         check($sformatf("vec%0d_state", i), int'(state_dbg), int'(vecs[i].st));
         check($sformatf("vec%0d_speed", i), int'(speed_index), int'(vecs[i].idx));
         check($sformatf("vec%0d_facing", i), int'(facing_left), int'(vecs[i].fl));
         check($sformatf("vec%0d_moving", i), int'(moving), int'(vecs[i].st != STOP));
      end

      l0 = left;
      repeat (50) cycle();
      check("stopped_left_const", int'(left), int'(l0));
      check("stopped_right_track", int'(right), int'(l0) + 31);

      // Step timing: 40 clk at speed 1, then 12 clk per pixel in RUN.
      do_reset();
      right_btn = 1'b1;
      tick();
      check("accel1_state", int'(state_dbg), int'(ACCEL));
      wait_left_change(100, n, ok);
      check("accel1_changed", int'(ok), 1);
      check("accel1_period", n, 40);
      check("accel1_left", int'(left), 101);
      repeat (3) tick();
      check("run_state", int'(state_dbg), int'(RUN));
      check("run_speed", int'(speed_index), 4);
      wait_left_change(100, n, ok);
      check("run_first_changed", int'(ok), 1);
      check("run_first_gap", n, 9);
      wait_left_change(100, n, ok);
      check("run_period", n, 12);
      check("run_left", int'(left), 103);
      check("run_right", int'(right), 134);

      // Asynchronous reset in mid-run takes effect without a clock edge.
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_left", int'(left), 100);
      check("async_rst_state", int'(state_dbg), int'(STOP));
      check("async_rst_speed", int'(speed_index), 0);
      check("async_rst_moving", int'(moving), 0);
      #8;
      rst = 1'b0;
      right_btn = 1'b0;

      wall_run(1'b1, 3000, 0);
      wall_run(1'b0, 10000, 608);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
